poly_eval_horner: RTL and testbench

//  Sequential polynomial evaluator: y = a_D*x^D + ... + a_1*x + a_0 (mod 2^WIDTH).

---
 rtl/poly_eval_pkg.sv | 18 +
 rtl/poly_mac.sv | 25 ++
 rtl/poly_eval_horner.sv | 183 ++++++++++++++++++
 tb/tb_poly_eval_horner.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package poly_eval_pkg;

    typedef enum logic [2:0] {
        S_LOAD        = 3'd0,
        S_LOAD_WAIT   = 3'd1,
        S_LOAD_X      = 3'd2,
        S_LOAD_X_WAIT = 3'd3,
        S_COMPUTE     = 3'd4,
        S_DONE        = 3'd5
    } state_e;

    // load_idx must reach D+1 (the x slot), hence D+2 distinct values
    function automatic int idx_width(input int degree);
        return $clog2(degree + 2);
    endfunction

endpackage

// File: rtl/poly_mac.sv
// Combinational multiply-add acc*x+a truncated to WIDTH; carry-out only with POLY_OVF_DETECT_EN.
module poly_mac #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
`ifdef POLY_OVF_DETECT_EN
    ,
    output logic             carry_o
`endif
);

`ifdef POLY_OVF_DETECT_EN
    logic [2*WIDTH:0] full_s;

    assign full_s  = (2*WIDTH+1)'(acc_i) * (2*WIDTH+1)'(x_i) + (2*WIDTH+1)'(a_i);
    assign y_o     = full_s[WIDTH-1:0];
    assign carry_o = |full_s[2*WIDTH:WIDTH];
`else
    assign y_o = acc_i * x_i + a_i;
`endif

endmodule

// File: rtl/poly_eval_horner.sv
// Sequential polynomial evaluator: go-handshake loading of a_D..a_0 and x, then Horner steps.
// Optional sticky overflow flag enabled by defining POLY_OVF_DETECT_EN.
module poly_eval_horner
    import poly_eval_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEGREE = 3,
    localparam int IW     = idx_width(DEGREE)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             keep_coeffs,
    input  logic [WIDTH-1:0] data_in,
    output logic [IW-1:0]    load_idx,
    output logic             busy,
    output logic [WIDTH-1:0] data_result,
    output logic             result_valid
`ifdef POLY_OVF_DETECT_EN
    ,
    output logic             overflow
`endif
);

    state_e           state_q, state_d;
    logic [IW-1:0]    load_idx_q, load_idx_d;
    logic [IW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] coef_q [0:DEGREE];
    logic [WIDTH-1:0] coef_d [0:DEGREE];
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] data_result_q, data_result_d;
    logic             busy_q, busy_d;
    logic             result_valid_q, result_valid_d;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] mac_y_s;
`ifdef POLY_OVF_DETECT_EN
    logic             mac_c_s;
    logic             ovf_q, ovf_d;
`endif

    // Select a_k: coefficients are stored in load order, so a_k sits at slot DEGREE-k
    always_comb begin
        a_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i <= DEGREE; i++) begin
            a_sel_s = (k_q == IW'(DEGREE - i)) ? coef_q[i] : a_sel_s;
        end
    end

    poly_mac #(.WIDTH(WIDTH)) u_mac (
        .acc_i   (acc_q),
        .x_i     (x_q),
        .a_i     (a_sel_s),
        .y_o     (mac_y_s)
`ifdef POLY_OVF_DETECT_EN
        ,
        .carry_o (mac_c_s)
`endif
    );

    // Next-state and datapath updates for the load/compute sequence
    always_comb begin
        state_d       = state_q;
        load_idx_d    = load_idx_q;
        k_d           = k_q;
        coef_d        = coef_q;
        x_d           = x_q;
        acc_d         = acc_q;
        data_result_d = data_result_q;
`ifdef POLY_OVF_DETECT_EN
        ovf_d         = ovf_q;
`endif
        case (state_q)
            S_LOAD: begin
                if (go) begin
                    for (int i = 0; i <= DEGREE; i++) begin
                        coef_d[i] = (load_idx_q == IW'(i)) ? data_in : coef_d[i];
                    end
                    state_d = S_LOAD_WAIT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD_WAIT: begin
                if (!go) begin
                    load_idx_d = load_idx_q + IW'(1);
                    state_d    = (load_idx_q < IW'(DEGREE)) ? S_LOAD : S_LOAD_X;
                end else begin
                    state_d = S_LOAD_WAIT;
                end
            end
            S_LOAD_X: begin
                if (go) begin
                    x_d     = data_in;
                    state_d = S_LOAD_X_WAIT;
                end else begin
                    state_d = S_LOAD_X;
                end
            end
            S_LOAD_X_WAIT: begin
                if (!go) begin
                    acc_d   = coef_q[0];
                    k_d     = IW'(DEGREE - 1);
`ifdef POLY_OVF_DETECT_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = S_COMPUTE;
                end else begin
                    state_d = S_LOAD_X_WAIT;
                end
            end
            S_COMPUTE: begin
                acc_d = mac_y_s;
`ifdef POLY_OVF_DETECT_EN
                ovf_d = ovf_q | mac_c_s;
`endif
                if (k_q == {IW{1'b0}}) begin
                    data_result_d = mac_y_s;
                    state_d       = S_DONE;
                end else begin
                    k_d = k_q - IW'(1);
                end
            end
            S_DONE: begin
                if (go && keep_coeffs) begin
                    x_d     = data_in;
                    state_d = S_LOAD_X_WAIT;
                end else if (go) begin
                    coef_d[0]  = data_in;
                    load_idx_d = {IW{1'b0}};
                    state_d    = S_LOAD_WAIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
        busy_d         = (state_d == S_COMPUTE);
        result_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset discards any partial load or computation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_LOAD;
            load_idx_q     <= {IW{1'b0}};
            k_q            <= {IW{1'b0}};
            coef_q         <= '{default: {WIDTH{1'b0}}};
            x_q            <= {WIDTH{1'b0}};
            acc_q          <= {WIDTH{1'b0}};
            data_result_q  <= {WIDTH{1'b0}};
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef POLY_OVF_DETECT_EN
            ovf_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            load_idx_q     <= load_idx_d;
            k_q            <= k_d;
            coef_q         <= coef_d;
            x_q            <= x_d;
            acc_q          <= acc_d;
            data_result_q  <= data_result_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
`ifdef POLY_OVF_DETECT_EN
            ovf_q          <= ovf_d;
`endif
        end
    end

    assign load_idx     = load_idx_q;
    assign busy         = busy_q;
    assign data_result  = data_result_q;
    assign result_valid = result_valid_q;
`ifdef POLY_OVF_DETECT_EN
    assign overflow     = ovf_q;
`endif

endmodule

// File: tb/tb_poly_eval_horner.sv
// Bench for poly_eval_horner: WIDTH=8/DEGREE=2 and WIDTH=16/DEGREE=4 instances against a power-sum model.
module tb_poly_eval_horner;

    logic        clk = 1'b0;
    logic        rstn_a, go_a, keep_a;
    logic [7:0]  data_a;
    logic [1:0]  idx_a;
    logic        busy_a, valid_a;
    logic [7:0]  res_a;
    logic        rstn_b, go_b, keep_b;
    logic [15:0] data_b;
    logic [2:0]  idx_b;
    logic        busy_b, valid_b;
    logic [15:0] res_b;
`ifdef POLY_OVF_DETECT_EN
    logic        ovf_a, ovf_b;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] mc [0:1][0:4];

    always #5 clk = ~clk;

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) dut_a (
        .clk(clk), .resetn(rstn_a), .go(go_a), .keep_coeffs(keep_a), .data_in(data_a),
        .load_idx(idx_a), .busy(busy_a), .data_result(res_a), .result_valid(valid_a)
`ifdef POLY_OVF_DETECT_EN
        , .overflow(ovf_a)
`endif
    );

    poly_eval_horner #(.WIDTH(16), .DEGREE(4)) dut_b (
        .clk(clk), .resetn(rstn_b), .go(go_b), .keep_coeffs(keep_b), .data_in(data_b),
        .load_idx(idx_b), .busy(busy_b), .data_result(res_b), .result_valid(valid_b)
`ifdef POLY_OVF_DETECT_EN
        , .overflow(ovf_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int deg(input int s);
        return (s == 0) ? 2 : 4;
    endfunction

    function automatic longint unsigned mask(input int s);
        return (s == 0) ? 64'hFF : 64'hFFFF;
    endfunction

    function automatic logic [15:0] f_res(input int s);
        return (s == 0) ? {8'h00, res_a} : res_b;
    endfunction

    function automatic logic f_busy(input int s);
        return (s == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic f_valid(input int s);
        return (s == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic [2:0] f_idx(input int s);
        return (s == 0) ? {1'b0, idx_a} : idx_b;
    endfunction

    // y = sum over i of a_i * x^i, everything mod 2^WIDTH; mc[s][0] holds a_D
    function automatic logic [15:0] model(input int s, input logic [15:0] xv);
        longint unsigned acc, p, x;
        int d;
        d = deg(s);
        x = longint'(xv) & mask(s);
        acc = 0;
        p = 1;
        for (int i = 0; i <= d; i++) begin
            acc = (acc + ((longint'(mc[s][d - i]) * p) & mask(s))) & mask(s);
            p = (p * x) & mask(s);
        end
        return acc[15:0];
    endfunction

`ifdef POLY_OVF_DETECT_EN
    function automatic logic model_ovf(input int s, input logic [15:0] xv);
        longint unsigned acc, full, x;
        logic o;
        x = longint'(xv) & mask(s);
        acc = longint'(mc[s][0]);
        o = 1'b0;
        for (int i = 1; i <= deg(s); i++) begin
            full = acc * x + longint'(mc[s][i]);
            if (full > mask(s)) o = 1'b1;
            acc = full & mask(s);
        end
        return o;
    endfunction
`endif

    task automatic set_in(input int s, input logic g, input logic [15:0] v, input logic kp);
        if (s == 0) begin
            go_a = g; data_a = v[7:0]; keep_a = kp;
        end else begin
            go_b = g; data_b = v; keep_b = kp;
        end
    endtask

    task automatic press(input int s, input logic [15:0] v, input logic kp, input int hold);
        set_in(s, 1'b1, v, kp);
        repeat (hold) @(negedge clk);
        set_in(s, 1'b0, v, kp);
    endtask

    task automatic run_eval(input int s, input bit full, input logic [15:0] xv, input int hold,
                            input string tag);
        int d, cnt, bcnt;
        logic [15:0] prev, exp;
        d = deg(s);
        if (full) begin
            for (int i = 0; i <= d; i++) begin
                press(s, mc[s][i], 1'b0, hold);
                chk({tag, "_idx_hold"}, 32'(f_idx(s)), 32'(i));
                @(negedge clk);
                chk({tag, "_idx_step"}, 32'(f_idx(s)), 32'(i + 1));
            end
        end
        prev = f_res(s);
        press(s, xv, !full, hold);
        exp = model(s, xv);
        cnt = 0;
        bcnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (f_busy(s)) begin
                bcnt++;
                chk({tag, "_stale"}, 32'(f_res(s)), 32'(prev));
            end
            if (f_valid(s)) break;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(d + 1));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(d));
        chk({tag, "_result"}, 32'(f_res(s)), 32'(exp));
        chk({tag, "_idx_x"}, 32'(f_idx(s)), 32'(d + 1));
`ifdef POLY_OVF_DETECT_EN
        chk({tag, "_ovf"}, 32'((s == 0) ? ovf_a : ovf_b), 32'(model_ovf(s, xv)));
`endif
    endtask

    task automatic chk_reset(input int s, input string tag);
        chk({tag, "_res"}, 32'(f_res(s)), 32'h0);
        chk({tag, "_valid"}, 32'(f_valid(s)), 32'h0);
        chk({tag, "_busy"}, 32'(f_busy(s)), 32'h0);
        chk({tag, "_idx"}, 32'(f_idx(s)), 32'h0);
`ifdef POLY_OVF_DETECT_EN
        chk({tag, "_ovf"}, 32'((s == 0) ? ovf_a : ovf_b), 32'h0);
`endif
    endtask

    initial begin
        rstn_a = 1'b0; go_a = 1'b0; keep_a = 1'b0; data_a = 8'h00;
        rstn_b = 1'b0; go_b = 1'b0; keep_b = 1'b0; data_b = 16'h0000;
        repeat (2) @(negedge clk);
        chk_reset(0, "rst_a");
        chk_reset(1, "rst_b");
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(negedge clk);

        // Directed: 1 2 3 at x=4, then reuse coefficients at x=5
        mc[0][0] = 16'd1; mc[0][1] = 16'd2; mc[0][2] = 16'd3;
        run_eval(0, 1'b1, 16'd4, 1, "t1");
        chk("t1_const", 32'(res_a), 32'h1B);
        run_eval(0, 1'b0, 16'd5, 1, "t2");
        chk("t2_const", 32'(res_a), 32'h26);

        // Wrap-around: 16*16 overflows the 8-bit accumulator
        mc[0][0] = 16'd16; mc[0][1] = 16'd0; mc[0][2] = 16'd0;
        run_eval(0, 1'b1, 16'd16, 1, "t3a");
        chk("t3a_const", 32'(res_a), 32'h00);
        run_eval(0, 1'b0, 16'd2, 1, "t3b");
        chk("t3b_const", 32'(res_a), 32'h40);

        // Long go presses must load exactly one value each
        for (int i = 0; i <= 2; i++) mc[0][i] = 16'($urandom_range(0, 255));
        run_eval(0, 1'b1, 16'($urandom_range(0, 255)), 20, "t4");

        for (int r = 0; r < 6; r++) begin
            bit full;
            full = 1'($urandom_range(0, 1));
            if (full) begin
                for (int i = 0; i <= 2; i++) mc[0][i] = 16'($urandom_range(0, 255));
            end
            run_eval(0, full, 16'($urandom_range(0, 255)), int'($urandom_range(1, 3)), "rnd_a");
        end

        // Asynchronous reset in the middle of a computation
        for (int i = 0; i <= 2; i++) mc[0][i] = 16'($urandom_range(1, 255));
        for (int i = 0; i <= 2; i++) begin
            press(0, mc[0][i], 1'b0, 1);
            @(negedge clk);
        end
        press(0, 16'd7, 1'b0, 1);
        @(negedge clk);
        chk("t5_busy_before", 32'(busy_a), 32'h1);
        rstn_a = 1'b0;
        #1;
        chk_reset(0, "t5");
        @(negedge clk);
        rstn_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 2; i++) mc[0][i] = 16'($urandom_range(0, 255));
        run_eval(0, 1'b1, 16'($urandom_range(0, 255)), 1, "t5_after");

        // Wide instance: x^4 + 1 at x=3
        mc[1][0] = 16'd1; mc[1][1] = 16'd0; mc[1][2] = 16'd0; mc[1][3] = 16'd0; mc[1][4] = 16'd1;
        run_eval(1, 1'b1, 16'd3, 1, "t6");
        chk("t6_const", 32'(res_b), 32'h0052);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i <= 4; i++) mc[1][i] = 16'($urandom_range(0, 65535));
            run_eval(1, 1'b1, 16'($urandom_range(0, 65535)), int'($urandom_range(1, 2)), "rnd_b");
            run_eval(1, 1'b0, 16'($urandom_range(0, 65535)), 1, "rnd_b_keep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
